// File: rtl/fft_twiddle_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT.
// Walks stages 0..LOG2_N-1 and butterflies 0..N/2-1. A two-stage pipeline
// presents {addr_a, addr_b, stage, last_bf} together with the ROM twiddle.
// Between stages it waits in DRAIN for stage_ack before touching the RAM again.
module fft_twiddle_sequencer #(
    parameter int LOG2_N  = 8,
    parameter int STAGE_W = $clog2(LOG2_N)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stage_ack,
    input  logic               bf_ready,
    output logic               busy,
    output logic               done,
    output logic [LOG2_N-2:0]  tw_addr,
    output logic [LOG2_N-1:0]  addr_a,
    output logic [LOG2_N-1:0]  addr_b,
    output logic               bf_valid,
    output logic [STAGE_W-1:0] stage,
    output logic               last_bf
);

    localparam int KW = LOG2_N - 1;
    localparam logic [KW-1:0]      K_LAST = '1;
    localparam logic [KW-1:0]      K_ONE  = KW'(1);
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2_N - 1);
    localparam logic [STAGE_W-1:0] S_ONE  = STAGE_W'(1);
    localparam logic [LOG2_N-1:0]  A_ONE  = LOG2_N'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN} state_t;

    typedef struct packed {
        logic [KW-1:0]     tw;
        logic [LOG2_N-1:0] a;
        logic [LOG2_N-1:0] b;
    } bf_addr_t;

    // Butterfly k of stage s: insert a zero at bit s of k to get the upper
    // address; the lower partner sets that bit. The twiddle index is the
    // position inside the group scaled up to the N/2-entry ROM.
    function automatic bf_addr_t map_bf(input logic [KW-1:0] k, input logic [STAGE_W-1:0] s);
        bf_addr_t          r;
        logic [LOG2_N-1:0] kx;
        logic [LOG2_N-1:0] half;
        logic [LOG2_N-1:0] pos;
        kx   = {1'b0, k};
        half = A_ONE << s;
        pos  = kx & (half - A_ONE);
        r.a  = (((kx >> s) << s) << 1) | pos;
        r.b  = r.a | half;
        r.tw = pos[KW-1:0] << (KW - int'(s));
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q;
    logic [STAGE_W-1:0] s_q;
    logic               issued_q;

    logic [KW-1:0]      tw_p1, tw_p2;
    logic [LOG2_N-1:0]  a_p1, a_p2, b_p1, b_p2;
    logic [STAGE_W-1:0] stage_p1, stage_p2;
    logic               last_p1, last_p2;
    logic               vld_p1, vld_p2;

    logic               advance;
    logic               issue;
    logic               accept_last;
    bf_addr_t           bf_k;

    assign advance     = !vld_p2 || bf_ready;
    assign issue       = (state_q == ST_RUN) && !issued_q;
    assign accept_last = vld_p2 && bf_ready && last_p2;
    assign bf_k        = map_bf(k_q, s_q);

    assign addr_a   = a_p2;
    assign addr_b   = b_p2;
    assign stage    = stage_p2;
    assign last_bf  = last_p2;
    assign bf_valid = vld_p2;
    // The ROM registers its address, so point it at whatever S2 will hold
    // after this edge: the S1 entry when moving, the S2 entry when stalled.
    assign tw_addr  = advance ? tw_p1 : tw_p2;

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and status outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (accept_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (stage_ack) state_d = (s_q == S_LAST) ? ST_FIN : ST_RUN;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Butterfly/stage counters; issue stops after k = N/2-1 until the next stage opens
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k_q      <= '0;
            s_q      <= '0;
            issued_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            k_q      <= '0;
            s_q      <= '0;
            issued_q <= 1'b0;
        end else if (state_q == ST_DRAIN && stage_ack && s_q != S_LAST) begin
            k_q      <= '0;
            s_q      <= s_q + S_ONE;
            issued_q <= 1'b0;
        end else if (issue && advance) begin
            k_q <= k_q + K_ONE;
            if (k_q == K_LAST) issued_q <= 1'b1;
        end
    end

    // ---- S1: address generation for the next butterfly ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            tw_p1    <= '0;
            a_p1     <= '0;
            b_p1     <= '0;
            stage_p1 <= '0;
            last_p1  <= 1'b0;
        end else if (advance) begin
            vld_p1 <= issue;
            if (issue) begin
                tw_p1    <= bf_k.tw;
                a_p1     <= bf_k.a;
                b_p1     <= bf_k.b;
                stage_p1 <= s_q;
                last_p1  <= (k_q == K_LAST);
            end
        end
    end

    // ---- S2: presented butterfly, held while bf_valid & !bf_ready ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p2   <= 1'b0;
            tw_p2    <= '0;
            a_p2     <= '0;
            b_p2     <= '0;
            stage_p2 <= '0;
            last_p2  <= 1'b0;
        end else if (advance) begin
            vld_p2   <= vld_p1;
            tw_p2    <= tw_p1;
            a_p2     <= a_p1;
            b_p2     <= b_p1;
            stage_p2 <= stage_p1;
            last_p2  <= last_p1;
        end
    end

endmodule
